// File: rtl/l2_arb_pkg.sv
// Shared types and default sizes for the L2 request-port arbiter.
package l2_arb_pkg;

    localparam int unsigned S_LINE_DEF = 256;
    localparam int unsigned S_ADDR_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

    typedef enum logic {
        SRC_I,
        SRC_D
    } arb_src_t;

endpackage

// File: rtl/l2_arbiter_rr2.sv
// Two-request round-robin picker: combinational grant, registered last winner.
module arb_rr2
    import l2_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic req_d,
    input  logic accept,
    output logic gnt_i,
    output logic gnt_d
);

    arb_src_t last_grant;

    // On a tie the side that did not win last time gets the grant.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (req_i && req_d) begin
            if (last_grant == SRC_D) begin
                gnt_i = 1'b1;
            end else begin
                gnt_d = 1'b1;
            end
        end else begin
            gnt_i = req_i;
            gnt_d = req_d;
        end
    end

    // Remember the winner only when the grant is actually taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= SRC_D;
        end else if (accept && gnt_i) begin
            last_grant <= SRC_I;
        end else if (accept && gnt_d) begin
            last_grant <= SRC_D;
        end
    end

endmodule

// File: rtl/l2_arbiter.sv
// Shares the single L2 request port between the I-side and D-side line adapters.
// One transaction at a time; the grant is held until l2_resp.
module l2_arbiter
    import l2_arb_pkg::*;
#(
    parameter int unsigned s_line = S_LINE_DEF,
    parameter int unsigned s_addr = S_ADDR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [s_addr-1:0] i_address,
    output logic [s_line-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [s_addr-1:0] d_address,
    input  logic [s_line-1:0] d_wdata,
    output logic [s_line-1:0] d_rdata,
    output logic              d_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [s_addr-1:0] l2_address,
    output logic [s_line-1:0] l2_wdata,
    input  logic [s_line-1:0] l2_rdata,
    input  logic              l2_resp
);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic              read_q;
    logic              write_q;
    logic [s_addr-1:0] addr_q;
    logic [s_line-1:0] wdata_q;
    logic              req_i;
    logic              req_d;
    logic              gnt_i;
    logic              gnt_d;
    logic              in_idle;

    assign req_i   = i_read;
    assign req_d   = d_read | d_write;
    assign in_idle = (state_q == IDLE);

    arb_rr2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req_i  (req_i),
        .req_d  (req_d),
        .accept (in_idle),
        .gnt_i  (gnt_i),
        .gnt_d  (gnt_d)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and combinational response steering.
    always_comb begin
        state_d = state_q;
        i_resp  = 1'b0;
        d_resp  = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_i) begin
                    state_d = SERVE_I;
                end else if (gnt_d) begin
                    state_d = SERVE_D;
                end
            end
            SERVE_I: begin
                i_resp = l2_resp;
                if (l2_resp) begin
                    state_d = IDLE;
                end
            end
            SERVE_D: begin
                d_resp = l2_resp;
                if (l2_resp) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latch the granted request; the L2 strobes clear on the response edge.
    // A D-side request with both read and write set is issued as a write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (in_idle) begin
            if (gnt_i) begin
                read_q  <= 1'b1;
                write_q <= 1'b0;
                addr_q  <= i_address;
                wdata_q <= '0;
            end else if (gnt_d) begin
                read_q  <= ~d_write;
                write_q <= d_write;
                addr_q  <= d_address;
                wdata_q <= d_wdata;
            end
        end else if (l2_resp) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
        end
    end

    assign l2_read    = read_q;
    assign l2_write   = write_q;
    assign l2_address = addr_q;
    assign l2_wdata   = wdata_q;

    assign i_rdata = l2_rdata;
    assign d_rdata = l2_rdata;

    a_rd_wr_exclusive : assert property (@(posedge clk) disable iff (!rst)
        !(l2_read && l2_write));

    a_resp_exclusive : assert property (@(posedge clk) disable iff (!rst)
        !(i_resp && d_resp));

    a_write_wins : assert property (@(posedge clk) disable iff (!rst)
        (in_idle && gnt_d && d_write) |=> (l2_write && !l2_read));

    a_hold_until_resp : assert property (@(posedge clk) disable iff (!rst)
        (!in_idle && !l2_resp) |=>
            ($stable(l2_address) && $stable(l2_read) && $stable(l2_write) && $stable(l2_wdata)));

endmodule
